regfile_wb_arbiter: RTL and testbench

//   Round-robin arbiter for the single write port of the 32x32 register file.

---
 rtl/regfile_wb_arbiter_if.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus shared by all requesters of the register file write port.
// Requester i owns bit i of valid/ready and its slice of addr/data.
interface regfile_wb_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]    req_valid;
    logic [5*N_REQ-1:0]  req_addr;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port.
// One writeback accepted per cycle, issued from a single output register.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus,
    output logic [4:0]          rf_address_W,
    output logic [31:0]         rf_write_data,
    output logic                rf_write_enable,
    output logic                grant_valid,
    output logic [CNT_W-1:0]    conflict_cnt
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] nxt_ptr;
    logic             found;
    logic [4:0]       sel_addr;
    logic [31:0]      sel_data;
    logic             multi;

    // Search from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        win_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found    = 1'b1;
                win_idx  = PTR_W'(idx);
                sel_addr = bus.req_addr[idx*5 +: 5];
                sel_data = bus.req_data[idx*32 +: 32];
            end
        end
    end

    // One-hot grant, suppressed while reset is asserted.
    always_comb begin
        grant_valid   = found & ~rst;
        bus.req_ready = '0;
        if (grant_valid) bus.req_ready[win_idx] = 1'b1;
    end

    // Next pointer after the winner, explicit wrap for non-power-of-two N_REQ.
    always_comb begin
        nxt_ptr = win_idx + 1'b1;
        if (win_idx == PTR_W'(N_REQ - 1)) nxt_ptr = '0;
    end

    // Two or more requesters active means contention this cycle.
    always_comb begin
        multi = (bus.req_valid & (bus.req_valid - 1'b1)) != '0;
    end

    // Round-robin pointer only moves on an accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= nxt_ptr;
        end
    end

    // Output register: winner issued next cycle, writes to $0 are swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_address_W    <= '0;
            rf_write_data   <= '0;
            rf_write_enable <= 1'b0;
        end else if (grant_valid) begin
            rf_address_W    <= sel_addr;
            rf_write_data   <= sel_data;
            rf_write_enable <= (sel_addr != 5'd0);
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

    // Saturating count of contention cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (multi && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset,
// round-robin and counter saturation sequences.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.N_REQ(3)) bus ();
    regfile_wb_arbiter_if #(.N_REQ(3)) bus4 ();

    logic [4:0]  rf_a;
    logic [31:0] rf_d;
    logic        rf_we;
    logic        gv;
    logic [15:0] cnt;

    logic [4:0]  rf_a4;
    logic [31:0] rf_d4;
    logic        rf_we4;
    logic        gv4;
    logic [3:0]  cnt4;

    regfile_wb_arbiter #(.N_REQ(3), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .rf_address_W    (rf_a),
        .rf_write_data   (rf_d),
        .rf_write_enable (rf_we),
        .grant_valid     (gv),
        .conflict_cnt    (cnt)
    );

    regfile_wb_arbiter #(.N_REQ(3), .CNT_W(4)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus4),
        .rf_address_W    (rf_a4),
        .rf_write_data   (rf_d4),
        .rf_write_enable (rf_we4),
        .grant_valid     (gv4),
        .conflict_cnt    (cnt4)
    );

    typedef struct packed {
        logic [2:0]  v;
        logic [14:0] a;
        logic [95:0] d;
        logic [2:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl [11];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid  = 3'b111;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus4.req_valid = '0;
        bus4.req_addr  = '0;
        bus4.req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_gv", 32'(gv), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_addr", 32'(rf_a), 32'd0);
        chk("rst_data", rf_d, 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        bus.req_valid = '0;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{3'b010, {5'd0, 5'd5, 5'd0},
                    {32'h0, 32'hDEADBEEF, 32'h0},
                    3'b010, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[1]  = '{3'b011, {5'd0, 5'd9, 5'd7},
                    {32'h0, 32'h22222222, 32'h11111111},
                    3'b001, 1'b1, 5'd7, 32'h11111111};
        tbl[2]  = '{3'b011, {5'd0, 5'd9, 5'd0},
                    {32'h0, 32'h22222222, 32'h00001234},
                    3'b010, 1'b1, 5'd9, 32'h22222222};
        tbl[3]  = '{3'b001, {5'd0, 5'd0, 5'd0},
                    {32'h0, 32'h0, 32'h00001234},
                    3'b001, 1'b0, 5'd0, 32'h00001234};
        tbl[4]  = '{3'b000, 15'd0, 96'd0,
                    3'b000, 1'b0, 5'd0, 32'h00001234};
        tbl[5]  = '{3'b100, {5'd31, 5'd0, 5'd0},
                    {32'hCAFEF00D, 32'h0, 32'h0},
                    3'b100, 1'b1, 5'd31, 32'hCAFEF00D};
        tbl[6]  = '{3'b101, {5'd4, 5'd0, 5'd3},
                    {32'h0BADF00D, 32'h0, 32'hAAAA5555},
                    3'b001, 1'b1, 5'd3, 32'hAAAA5555};
        tbl[7]  = '{3'b100, {5'd4, 5'd0, 5'd0},
                    {32'h0BADF00D, 32'h0, 32'h0},
                    3'b100, 1'b1, 5'd4, 32'h0BADF00D};
        tbl[8]  = '{3'b110, {5'd12, 5'd12, 5'd0},
                    {32'h34343434, 32'h12121212, 32'h0},
                    3'b010, 1'b1, 5'd12, 32'h12121212};
        tbl[9]  = '{3'b100, {5'd12, 5'd0, 5'd0},
                    {32'h34343434, 32'h0, 32'h0},
                    3'b100, 1'b1, 5'd12, 32'h34343434};
        tbl[10] = '{3'b000, 15'd0, 96'd0,
                    3'b000, 1'b0, 5'd12, 32'h34343434};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            bus.req_valid = tbl[i].v;
            bus.req_addr  = tbl[i].a;
            bus.req_data  = tbl[i].d;
            #3;
            chk($sformatf("ready[%0d]", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
            chk($sformatf("gv[%0d]", i), 32'(gv), 32'(tbl[i].v != 3'b000));
            @(posedge clk);
            #1;
            chk($sformatf("we[%0d]", i), 32'(rf_we), 32'(tbl[i].we));
            chk($sformatf("wa[%0d]", i), 32'(rf_a), 32'(tbl[i].wa));
            chk($sformatf("wd[%0d]", i), rf_d, tbl[i].wd);
        end
        chk("tbl_cnt", 32'(cnt), 32'd4);

        do_reset();
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {32'hC0000003, 32'hB0000002, 32'hA0000001};
        for (int k = 0; k < 6; k++) begin
            #3;
            chk($sformatf("rr_ready[%0d]", k), 32'(bus.req_ready),
                32'(3'b001 << (k % 3)));
            @(posedge clk);
            #1;
            chk($sformatf("rr_we[%0d]", k), 32'(rf_we), 32'd1);
            chk($sformatf("rr_wa[%0d]", k), 32'(rf_a), 32'((k % 3) + 1));
        end
        chk("rr_cnt", 32'(cnt), 32'd6);
        bus.req_valid = '0;

        do_reset();
        bus.req_valid = 3'b011;
        bus.req_addr  = {5'd0, 5'd2, 5'd1};
        bus.req_data  = {32'h0, 32'h22, 32'h11};
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_we", 32'(rf_we), 32'd1);
        chk("pre_rst_wa", 32'(rf_a), 32'd2);
        chk("pre_rst_cnt", 32'(cnt), 32'd2);
        bus.req_valid = 3'b111;
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_gv", 32'(gv), 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_cnt", 32'(cnt), 32'd0);
        bus.req_valid = '0;

        do_reset();
        bus4.req_valid = 3'b011;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 14 || n == 15 || n == 20)
                chk($sformatf("sat_cnt[%0d]", n), 32'(cnt4),
                    32'((n < 15) ? n : 15));
        end
        bus4.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
